// File: rtl/neurex_pkg.sv
`default_nettype none
// ============================================================================
// neurex_pkg : shared widths, accumulator-read FSM states, requantize helper
// Rev 1.0
// ============================================================================
package neurex_pkg;

    localparam int NEUREX_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } accum_rd_state_t;

    function automatic int psum_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Width-agnostic requantizer; callers sign-extend into 64 bits and
    // truncate the already-saturated result back to their data width.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] psum,
        input int unsigned        shift,
        input logic               relu_en,
        input int unsigned        data_width = NEUREX_DATA_WIDTH
    );
        int unsigned        sh;
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = (shift > data_width) ? data_width : shift;
        s  = psum >>> sh;
        if (relu_en && (s < 0)) begin
            s = '0;
        end
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_width - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_skid_fifo.sv
`default_nettype none
// ============================================================================
// row_skid_fifo : 2-entry row buffer with per-entry last flag
// Rev 1.0
// ============================================================================
module row_skid_fifo #(
    parameter int SYS_COL    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data [0:SYS_COL-1],
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head [0:SYS_COL-1],
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] r_mem [0:1][0:SYS_COL-1];
    logic [1:0]            r_last;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    // Push into the slot being popped is safe when full: the head leaves this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < 2; e++) begin
                for (int c = 0; c < SYS_COL; c++) begin
                    r_mem[e][c] <= '0;
                end
            end
            r_last   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                for (int c = 0; c < SYS_COL; c++) begin
                    r_mem[r_wr_ptr][c] <= push_data[c];
                end
                r_last[r_wr_ptr] <= push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    generate
        for (genvar c = 0; c < SYS_COL; c++) begin : g_head
            assign head[c] = r_mem[r_rd_ptr][c];
        end
    endgenerate

    assign head_last = r_last[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/accum_rd_ctrl.sv
`default_nettype none
// ============================================================================
// accum_rd_ctrl : drains accumulator rows, requantizes, streams whole rows
// Rev 1.0
// ============================================================================
module accum_rd_ctrl
    import neurex_pkg::*;
#(
    parameter int SYS_COL    = 4,
    parameter int DATA_WIDTH = NEUREX_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [DATA_WIDTH-1:0]                 num_row,
    input  logic                                  relu_en,
    input  logic [$clog2(DATA_WIDTH):0]           shift,
    output logic [SYS_COL-1:0]                    rd_en,
    output logic [ADDR_WIDTH-1:0]                 rd_addr [0:SYS_COL-1],
    input  logic [psum_width(DATA_WIDTH)-1:0]     rd_data [0:SYS_COL-1],
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data [0:SYS_COL-1],
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int PSUM_WIDTH  = psum_width(DATA_WIDTH);
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1;

    accum_rd_state_t r_state;
    accum_rd_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_base;
    logic [DATA_WIDTH-1:0]  r_num;
    logic                   r_relu;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0]  r_issued;
    logic [DATA_WIDTH-1:0]  r_accepted;
    logic                   r_inflight;
    logic                   r_inflight_last;

    logic                   w_pop;
    logic                   w_issue;
    logic [2:0]             w_load;
    logic [DATA_WIDTH-1:0]  w_accepted_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [1:0]             w_count;
    logic                   w_head_last;
    logic [DATA_WIDTH-1:0]  w_req  [0:SYS_COL-1];
    logic [DATA_WIDTH-1:0]  w_head [0:SYS_COL-1];

    assign w_pop          = out_valid & out_ready;
    assign w_accepted_nxt = r_accepted + DATA_WIDTH'(w_pop);

    // Credit: outstanding reads plus buffered rows, net of this cycle's pop,
    // must leave room in the 2-entry FIFO for the row being requested now.
    assign w_load  = 3'(r_inflight) + 3'(w_count) - 3'(w_pop);
    assign w_issue = (r_state == READ) && (r_issued < r_num) && (w_load < 3'd2);
    assign w_addr  = r_base + ADDR_WIDTH'(r_issued);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_row == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (r_issued == r_num) begin
                    w_state_nxt = DRAIN;
                end
            end
            // Leave on the final handshake so done lands in the very next cycle.
            DRAIN: begin
                if (w_accepted_nxt == r_num) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base          <= '0;
            r_num           <= '0;
            r_relu          <= 1'b0;
            r_shift         <= '0;
            r_issued        <= '0;
            r_accepted      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_base     <= base_addr;
                r_num      <= num_row;
                r_relu     <= relu_en;
                r_shift    <= shift;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + DATA_WIDTH'(1);
                end
                r_accepted <= w_accepted_nxt;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issued == (r_num - DATA_WIDTH'(1)));
        end
    end

    generate
        for (genvar c = 0; c < SYS_COL; c++) begin : g_lane
            assign rd_addr[c] = w_addr;
            assign w_req[c]   = DATA_WIDTH'(requant(
                                    {{(64-PSUM_WIDTH){rd_data[c][PSUM_WIDTH-1]}}, rd_data[c]},
                                    32'(r_shift), r_relu, DATA_WIDTH));
            assign out_data[c] = w_head[c];
        end
    endgenerate

    row_skid_fifo #(
        .SYS_COL    (SYS_COL),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (r_inflight),
        .push_data (w_req),
        .push_last (r_inflight_last),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head),
        .head_last (w_head_last)
    );

    assign rd_en     = {SYS_COL{w_issue}};
    assign out_valid = (w_count != 2'd0);
    assign out_last  = out_valid & w_head_last;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_accum_rd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_accum_rd_ctrl : directed, table-driven bench for accum_rd_ctrl
// Rev 1.0
// ============================================================================
module tb_accum_rd_ctrl;

    localparam int SYS_COL     = 4;
    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 8;
    localparam int PSUM_WIDTH  = 32;
    localparam int SHIFT_WIDTH = 5;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [DATA_WIDTH-1:0]  num_row;
    logic                   relu_en;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [SYS_COL-1:0]     rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr  [0:SYS_COL-1];
    logic [PSUM_WIDTH-1:0]  rd_data  [0:SYS_COL-1];
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data [0:SYS_COL-1];
    logic                   out_last;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    accum_rd_ctrl #(
        .SYS_COL    (SYS_COL),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .num_row   (num_row),
        .relu_en   (relu_en),
        .shift     (shift),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Accumulator banks: one-cycle read latency.
    logic [PSUM_WIDTH-1:0] bank [0:SYS_COL-1][0:255];
    always @(posedge clk) begin
        for (int c = 0; c < SYS_COL; c++) begin
            rd_data[c] <= bank[c][rd_addr[c]];
        end
    end

    typedef struct {
        logic [63:0] data;
        logic        last;
    } row_t;

    typedef struct {
        logic [127:0]           psum;
        logic [SHIFT_WIDTH-1:0] sh;
        logic                   relu;
        logic [63:0]            exp;
    } qvec_t;

    int          total = 0;
    int          bad   = 0;
    row_t        exp_q  [$];
    logic [7:0]  addr_q [$];
    int          mon_issued;
    int          mon_accepted;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {out_data[0], out_data[1], out_data[2], out_data[3]};
    endfunction

    task automatic push_row(input int r, input logic last);
        row_t e;
        e.data = {16'(100*r), 16'(100*r+1), 16'(100*r+2), 16'(100*r+3)};
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},    64'(rd_en), 64'd0);
        check({tag, "_rd_addr"},  64'(rd_addr[0]), 64'd0);
        check({tag, "_valid"},    64'(out_valid), 64'd0);
        check({tag, "_data"},     pack_out(), 64'd0);
        check({tag, "_last"},     64'(out_last), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
    endtask

    // Stream monitor: ordering, last flag, stall stability, read credit.
    always @(negedge clk) begin
        if (rstn) begin
            if (rd_en != '0) begin
                check("rd_en_bits", 64'(rd_en), 64'hF);
                check("rd_addr_eq", {40'd0, rd_addr[1], rd_addr[2], rd_addr[3]},
                      {40'd0, rd_addr[0], rd_addr[0], rd_addr[0]});
                addr_q.push_back(rd_addr[0]);
                mon_issued++;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", pack_out(), prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_row: got %0h expected none", pack_out());
                end else begin
                    row_t r;
                    r = exp_q.pop_front();
                    check("row_data", pack_out(), r.data);
                    check("row_last", 64'(out_last), 64'(r.last));
                end
                mon_accepted++;
            end
            if (rd_en != '0) begin
                check("credit_le2", 64'(mon_issued - mon_accepted), 64'(((mon_issued - mon_accepted) <= 2) ? (mon_issued - mon_accepted) : 2));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = pack_out();
        end else begin
            prev_stall = 1'b0;
        end
    end

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,...
    task automatic run_job(input logic [7:0] base, input logic [15:0] num,
                           input logic [SHIFT_WIDTH-1:0] sh, input logic relu,
                           input int mode, input int mid_cyc);
        int last_hs;
        int dones;
        bit fin;
        mon_issued   = 0;
        mon_accepted = 0;
        addr_q.delete();
        last_hs = -1;
        dones   = 0;
        fin     = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(posedge clk);
            #1;
            start     = (cyc == 0) || (cyc == mid_cyc);
            base_addr = (cyc == 0) ? base : 8'd200;
            num_row   = (cyc == 0) ? num  : 16'd1;
            shift     = (cyc == 0) ? sh   : 5'd3;
            relu_en   = (cyc == 0) ? relu : ~relu;
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            @(negedge clk);
            if (out_valid && out_ready && out_last) last_hs = cyc;
            if (done) begin
                dones++;
                check("done_timing", 64'(cyc), 64'((num == 0) ? 1 : last_hs + 1));
            end else if (dones > 0) begin
                check("busy_after_done", 64'(busy), 64'd0);
                check("done_pulses", 64'(dones), 64'd1);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        check("job_finished", 64'(fin), 64'd1);
        check("rows_left", 64'(exp_q.size()), 64'd0);
        check("rows_accepted", 64'(mon_accepted), 64'(num));
    endtask

    qvec_t qtab [6];

    initial begin
        qtab[0] = '{psum: {32'hFFFFFFFB, 32'h00011170, 32'hFFFEEE90, 32'h00000400}, sh: 5'd2,  relu: 1'b1,
                    exp: {16'h0000, 16'h445C, 16'h0000, 16'h0100}};
        qtab[1] = '{psum: {32'hFFFFFFFB, 32'h00011170, 32'hFFFEEE90, 32'h00000400}, sh: 5'd0,  relu: 1'b0,
                    exp: {16'hFFFB, 16'h7FFF, 16'h8000, 16'h0400}};
        qtab[2] = '{psum: {32'hFFFFFFFF, 32'h00030005, 32'hFFFF0000, 32'h7FFFFFFF}, sh: 5'd16, relu: 1'b0,
                    exp: {16'hFFFF, 16'h0003, 16'hFFFF, 16'h7FFF}};
        qtab[3] = '{psum: {32'hFFFFFFFF, 32'h00030005, 32'hFFFF0000, 32'h7FFFFFFF}, sh: 5'd31, relu: 1'b0,
                    exp: {16'hFFFF, 16'h0003, 16'hFFFF, 16'h7FFF}};
        qtab[4] = '{psum: {32'hFFFFFFF0, 32'h00000640, 32'h00000021, 32'hFFFFFFFF}, sh: 5'd4,  relu: 1'b1,
                    exp: {16'h0000, 16'h0064, 16'h0002, 16'h0000}};
        qtab[5] = '{psum: {32'h00010001, 32'hFFFEFFFF, 32'h00000007, 32'hFFFFFFF9}, sh: 5'd1,  relu: 1'b0,
                    exp: {16'h7FFF, 16'h8000, 16'h0003, 16'hFFFC}};

        for (int r = 0; r < 256; r++) begin
            for (int c = 0; c < SYS_COL; c++) begin
                bank[c][r] = 32'(100*r + c);
            end
        end

        rstn = 1'b0; start = 1'b0; base_addr = '0; num_row = '0;
        relu_en = 1'b0; shift = '0; out_ready = 1'b0;
        mon_issued = 0; mon_accepted = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Basic 4-row job with exact cycle timing.
        for (int r = 0; r < 4; r++) push_row(r, r == 3);
        mon_issued = 0; mon_accepted = 0;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 0); base_addr = 8'd0; num_row = 16'd4;
            shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            check("A_busy",  64'(busy),      64'(cyc >= 1 && cyc <= 7));
            check("A_done",  64'(done),      64'(cyc == 7));
            check("A_rd_en", 64'(rd_en),     (cyc >= 1 && cyc <= 4) ? 64'hF : 64'h0);
            if (cyc >= 1 && cyc <= 4) check("A_rd_addr", 64'(rd_addr[0]), 64'(cyc - 1));
            check("A_valid", 64'(out_valid), 64'(cyc >= 3 && cyc <= 6));
            check("A_last",  64'(out_last),  64'(cyc == 6));
        end
        start = 1'b0;
        check("A_rows_left", 64'(exp_q.size()), 64'd0);

        // Backpressure with an ignored mid-job start.
        for (int r = 0; r < 6; r++) push_row(r, r == 5);
        run_job(8'd0, 16'd6, 5'd0, 1'b0, 1, 5);

        // Address wrap-around.
        push_row(254, 1'b0); push_row(255, 1'b0); push_row(0, 1'b0); push_row(1, 1'b1);
        run_job(8'd254, 16'd4, 5'd0, 1'b0, 0, -1);
        check("wrap_nreads", 64'(addr_q.size()), 64'd4);
        if (addr_q.size() == 4)
            check("wrap_addrs", {32'd0, addr_q[0], addr_q[1], addr_q[2], addr_q[3]}, 64'hFEFF0001);

        // Empty job.
        run_job(8'd7, 16'd0, 5'd0, 1'b0, 0, -1);
        check("zero_no_reads", 64'(mon_issued), 64'd0);

        // Reset in cycle 4 of an 8-row job, then a fresh job.
        for (int r = 0; r < 8; r++) push_row(r, r == 7);
        mon_issued = 0; mon_accepted = 0;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 0); base_addr = 8'd0; num_row = 16'd8;
            shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
            if (cyc == 4) rstn = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        push_row(5, 1'b0); push_row(6, 1'b1);
        run_job(8'd5, 16'd2, 5'd0, 1'b0, 0, -1);

        // Requantization table, one single-row job per record.
        for (int k = 0; k < 6; k++) begin
            row_t e;
            for (int c = 0; c < SYS_COL; c++) begin
                bank[c][60+k] = qtab[k].psum[127 - 32*c -: 32];
            end
            e.data = qtab[k].exp;
            e.last = 1'b1;
            exp_q.push_back(e);
            run_job(8'(60 + k), 16'd1, qtab[k].sh, qtab[k].relu, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/accum_rd_ctrl.md
# accum_rd_ctrl

Drains finished output rows from the accumulator banks once the systolic array has completed a tile. It is the read-side counterpart of the accumulator write controller. It issues one row read per cycle across all `SYS_COL` accumulator banks, requantizes each `PSUM_WIDTH` partial sum to `DATA_WIDTH` (arithmetic shift, optional ReLU, signed saturation), and presents whole rows on a valid/ready stream toward the output memory writer. Reads are credit-limited so that backpressure never drops a returning read.

## Interface
Parameters:
- `SYS_COL`, 4: number of accumulator banks, which is also the output row width in elements.
- `DATA_WIDTH`, 16: output element width, signed.
- `ADDR_WIDTH`, 8: accumulator row address width.
- `PSUM_WIDTH`, 2*DATA_WIDTH: accumulator element width, signed (localparam).
- `SHIFT_WIDTH`, $clog2(DATA_WIDTH)+1: width of `shift` (localparam).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; ignored unless IDLE.
- `base_addr` in ADDR_WIDTH: first accumulator row; sampled on `start`.
- `num_row` in DATA_WIDTH: number of rows to drain; sampled on `start`.
- `relu_en` in 1: clamp negatives to 0; sampled on `start`.
- `shift` in SHIFT_WIDTH: arithmetic right shift (0..DATA_WIDTH); sampled on `start`.
- `rd_en` out SYS_COL: per-bank read enable; all bits are equal.
- `rd_addr` out ADDR_WIDTH [0:SYS_COL-1]: per-bank read address; all entries are equal.
- `rd_data` in PSUM_WIDTH [0:SYS_COL-1]: bank data, valid 1 cycle after `rd_en`.
- `out_valid` out 1: `out_data` holds a row.
- `out_ready` in 1: consumer accepts the row.
- `out_data` out DATA_WIDTH [0:SYS_COL-1]: requantized row.
- `out_last` out 1: qualifies the final row of the job.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at job completion.

## Operation
- States:
  - IDLE: on `start`, go to READ, or to DONE if `num_row`==0.
  - READ: go to DRAIN when `issued`==`num_row`.
  - DRAIN: go to DONE when `accepted`==`num_row`.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read issue in READ when `issued`<`num_row` and `inflight + occupancy - pop < 2`. Here `pop = out_valid & out_ready`, `inflight` ∈{0,1}, and `occupancy` is the skid buffer count.
- `rd_addr` = (`base_addr` + `issued`) mod 2^ADDR_WIDTH. Wrap-around is legal and silent.
- Requantization for each element e:
  - s = e >>> `shift`. Sign extends; `shift`=0 passes the value through.
  - If `relu_en` and s<0, then s=0.
  - Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Values of `shift` greater than DATA_WIDTH are treated as DATA_WIDTH.
- Requantized rows are written into a 2-entry FIFO in the cycle the data returns. The head of the FIFO drives `out_data` and `out_valid`.
- `out_last` = `out_valid` and the head row is row index `num_row`-1.
- Simultaneous push and pop is legal at any occupancy, including full.
- The stream never stalls internally. Throughput is 1 row/cycle while `out_ready` is held high.
- `start` while busy: ignored, with no effect on the running job.
- Reset mid-job: `rst` abandons the job. All counters, the FIFO and the state clear immediately.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` in cycle 0 gives `busy` and the first `rd_en` in cycle 1.
- Data returns in cycle 2, and the first `out_valid` is in cycle 3. Latency from `rd_en` to `out_valid` is 2 cycles.
- `done` is asserted in the cycle after the handshake of the last row. `busy` drops in the cycle after `done`.
- `num_row`=0: `start` in cycle 0 gives `done` in cycle 1, with no `rd_en` and no `out_valid`.
- `out_valid` is stable while low `out_ready`: once asserted, it stays high with `out_data` unchanged until the handshake.

## Structure
- A shared package `neurex_pkg` holds:
  - the `PSUM_WIDTH` derivation;
  - the state enum `accum_rd_state_t` {IDLE, READ, DRAIN, DONE};
  - the function `requant(psum, shift, relu_en)`, which the output-path blocks reuse.
- One sub-module, `row_skid_fifo`: 2-entry, SYS_COL×DATA_WIDTH wide, with `push`, `pop`, `count`, `head` and per-entry last-flag storage.

## Test plan
- SYS_COL=4, banks preloaded with row r, column c = 100·r+c; `base_addr`=0, `num_row`=4, `shift`=0, `relu_en`=0, `out_ready`=1 → rows {0,1,2,3}…{300..303} in cycles 3–6; `out_last` in cycle 6; `done` in cycle 7.
- Same data with `out_ready` toggling 1,0,0,1,… → no row lost or duplicated, `out_data` held constant while stalled, and never more than 2 reads outstanding plus buffered.
- `base_addr`=254, `num_row`=4 → `rd_addr` sequence 254, 255, 0, 1.
- Row values {-5, 70000, -70000, 1024}:
  - `shift`=2, `relu_en`=1 → {0, 17500, 0, 256}.
  - `shift`=0, `relu_en`=0 → {-5, 32767, -32768, 1024}.
- `num_row`=0 → `done` in cycle 1 with no reads. A second `start` mid-job has no effect.
- `rstn` pulled low in cycle 4 of an 8-row job → all outputs return to their reset values. A new job started afterwards completes correctly.
